// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared FSM encodings and request-entry layout for the PSRAM byte initiator
package psram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WWAIT = 2'd2,
        ST_RWAIT = 2'd3
    } state_t;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 8;

    // Request entry = {write, address[21:0], wdata[7:0]}
    localparam int ENTRY_W         = 31;
    localparam int ENTRY_WDATA_LSB = 0;
    localparam int ENTRY_ADDR_LSB  = 8;
    localparam int ENTRY_WRITE_BIT = 30;

    function automatic logic [ENTRY_W-1:0] pack_entry(
        input logic              write,
        input logic [ADDR_W-1:0] address,
        input logic [DATA_W-1:0] wdata
    );
        return {write, address, wdata};
    endfunction

endpackage

// File: rtl/psram_req_fifo.sv
// rtl/psram_req_fifo.sv - synchronous first-word-fall-through request FIFO
module psram_req_fifo #(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    // DEPTH is a power of two, so the pointers wrap naturally.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/psram_byte_initiator.sv
// rtl/psram_byte_initiator.sv - queued byte requester for the PSRAM port; PSRAM_TIMEOUT_EN adds a read watchdog
module psram_byte_initiator
    import psram_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              idle,
    input  logic              initial_busy,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_en
);

    state_t               state;
    logic                 push;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head;
    logic                 wwait_first;

    // Not ready while reset is held, so nothing is queued into a flushing FIFO.
    assign req_ready  = n_reset & ~fifo_full;
    assign push       = req_valid & req_ready;
    assign push_entry = pack_entry(req_write, req_address, req_wdata);
    assign pop        = (state == ST_IDLE) & ~fifo_empty & ~initial_busy & ~mem_busy;
    assign idle       = (state == ST_IDLE) & fifo_empty;

    psram_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .n_reset   (n_reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef PSRAM_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0] wd_count;
`else
    // Watchdog compiled out; the comparison is constant false and only keeps the
    // parameter list identical between builds.
    assign rsp_timeout = (TIMEOUT_CYCLES < 0);
`endif

    // Command sequencer: issue one queued request, then wait for the port to finish it.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state       <= ST_IDLE;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            wwait_first <= 1'b0;
`ifdef PSRAM_TIMEOUT_EN
            rsp_timeout <= 1'b0;
            wd_count    <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
`ifdef PSRAM_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        mem_wr      <= head[ENTRY_WRITE_BIT];
                        mem_rd      <= ~head[ENTRY_WRITE_BIT];
                        mem_address <= head[ENTRY_ADDR_LSB +: ADDR_W];
                        mem_wdata   <= head[ENTRY_WDATA_LSB +: DATA_W];
                        state       <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    mem_rd      <= 1'b0;
                    mem_wr      <= 1'b0;
                    wwait_first <= 1'b1;
`ifdef PSRAM_TIMEOUT_EN
                    wd_count    <= '0;
`endif
                    state       <= mem_wr ? ST_WWAIT : ST_RWAIT;
                end
                ST_WWAIT: begin
                    // Busy is still rising on the first cycle, so it is not trusted yet.
                    if (wwait_first) begin
                        wwait_first <= 1'b0;
                    end else if (!mem_busy) begin
                        state <= ST_IDLE;
                    end
                end
                ST_RWAIT: begin
                    // Data takes priority over a coincident watchdog expiry.
                    if (mem_rdata_en) begin
                        rsp_rdata <= mem_rdata;
                        rsp_valid <= 1'b1;
                        state     <= ST_IDLE;
                    end
`ifdef PSRAM_TIMEOUT_EN
                    else if (wd_count == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        rsp_rdata   <= 8'hFF;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psram_byte_initiator.sv
// tb/tb_psram_byte_initiator.sv - randomized self-checking bench with PSRAM port model and reference queues
`timescale 1ns/1ps
module tb_psram_byte_initiator;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [21:0] req_address;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        idle;
    logic        initial_busy;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_busy;
    logic [21:0] mem_address;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_rdata_en;

    always #5 clk = ~clk;

    psram_byte_initiator #(
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_timeout  (rsp_timeout),
        .idle         (idle),
        .initial_busy (initial_busy),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .mem_busy     (mem_busy),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rdata_en (mem_rdata_en)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: requests in acceptance order, expected responses, host-view memory.
    logic [30:0] exp_issue [$];
    logic [8:0]  exp_rsp [$];
    logic [7:0]  ref_mem [logic [21:0]];
    logic [7:0]  psram_mem [logic [21:0]];

    function automatic logic [7:0] mem_default(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    // PSRAM port model state
    int          wr_busy_len = 3;
    int          rd_lat = 4;
    bit          rd_respond = 1'b1;
    logic        hold_busy;
    logic        manual_en;
    logic        model_busy = 1'b0;
    logic        model_en = 1'b0;
    int          busy_cnt = 0;
    int          rd_cnt = 0;
    logic [21:0] rd_addr = '0;
    bit          en_for_read = 1'b0;

    assign mem_busy     = model_busy | hold_busy;
    assign mem_rdata_en = model_en | manual_en;

    // What the DUT saw at the edge where it chose to issue.
    logic seen_block = 1'b1;
    always @(posedge clk) seen_block <= mem_busy | initial_busy;

    int          cyc = 0;
    int          n_issued = 0;
    int          n_rsp = 0;
    int          issue_cyc [$];
    int          last_rd_cyc = 0;
    int          last_rsp_cyc = 0;
    logic [7:0]  last_rsp_data = '0;
    logic        last_rsp_to = 1'b0;
    bit          prev_pulse = 1'b0;
    bit          prev_rsp = 1'b0;
    logic [21:0] last_addr = '0;
    logic [7:0]  last_wdata = '0;
    logic [30:0] e_issue;
    logic [8:0]  e_rsp;

    // Monitor and port model, evaluated away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (!n_reset) begin
            busy_cnt    = 0;
            rd_cnt      = 0;
            model_busy  = 1'b0;
            model_en    = 1'b0;
            en_for_read = 1'b0;
            prev_pulse  = 1'b0;
            prev_rsp    = 1'b0;
            last_addr   = '0;
            last_wdata  = '0;
        end else begin
            if (en_for_read) check("rsp_latency", rsp_valid, 1'b1);
            if (rsp_valid) begin
                check("rsp_width", prev_rsp, 1'b0);
                n_rsp++;
                last_rsp_cyc  = cyc;
                last_rsp_data = rsp_rdata;
                last_rsp_to   = rsp_timeout;
                if (exp_rsp.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    e_rsp = exp_rsp.pop_front();
                    check("rsp_data", {rsp_timeout, rsp_rdata}, e_rsp);
                end
            end
            prev_rsp = rsp_valid;

            if (mem_wr || mem_rd) begin
                check("pulse_exclusive", mem_wr & mem_rd, 1'b0);
                check("pulse_width", prev_pulse, 1'b0);
                check("issue_blocked", seen_block, 1'b0);
                n_issued++;
                issue_cyc.push_back(cyc);
                if (exp_issue.size() == 0) begin
                    check("issue_unexpected", 1'b1, 1'b0);
                end else begin
                    e_issue = exp_issue.pop_front();
                    check("issue_entry", {mem_wr, mem_address, mem_wdata}, e_issue);
                end
                last_addr  = mem_address;
                last_wdata = mem_wdata;
                if (mem_wr) begin
                    psram_mem[mem_address] = mem_wdata;
                    busy_cnt = wr_busy_len;
                end else begin
                    rd_addr     = mem_address;
                    rd_cnt      = rd_lat;
                    last_rd_cyc = cyc;
                end
            end else begin
                check("addr_hold", {mem_address, mem_wdata}, {last_addr, last_wdata});
                if (busy_cnt > 0) busy_cnt--;
            end
            prev_pulse = mem_wr | mem_rd;

            model_en    = 1'b0;
            en_for_read = 1'b0;
            if (rd_cnt > 0 && !(mem_wr || mem_rd)) begin
                rd_cnt--;
                if (rd_cnt == 0 && rd_respond) begin
                    model_en    = 1'b1;
                    en_for_read = 1'b1;
                    mem_rdata   = psram_mem.exists(rd_addr) ? psram_mem[rd_addr] : mem_default(rd_addr);
                end
            end
            model_busy = (busy_cnt > 0) || (rd_cnt > 0);
        end
    end

    task automatic push(input logic wr, input logic [21:0] a, input logic [7:0] d,
                        input bit expect_timeout = 1'b0);
        int waited;
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = a;
        req_wdata   = d;
        waited = 0;
        while (!req_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            check("push_stall", 1'b0, 1'b1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_issue.push_back({wr, a, d});
        if (wr) begin
            ref_mem[a] = d;
        end else if (expect_timeout) begin
            exp_rsp.push_back({1'b1, 8'hFF});
        end else begin
            exp_rsp.push_back({1'b0, ref_mem.exists(a) ? ref_mem[a] : mem_default(a)});
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_issued(input int n, input string tag);
        int waited = 0;
        while (n_issued < n && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check(tag, (n_issued >= n), 1'b1);
    endtask

    task automatic drain(input string tag);
        int waited = 0;
        while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || !idle) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        check(tag, (exp_issue.size() == 0 && exp_rsp.size() == 0 && idle), 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp"}, {rsp_valid, rsp_rdata, rsp_timeout}, '0);
        check({tag, "_mem"}, {mem_rd, mem_wr, mem_address, mem_wdata}, '0);
        check({tag, "_idle"}, idle, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        int rsp_base;
        n_reset      = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_address  = '0;
        req_wdata    = '0;
        initial_busy = 1'b1;
        hold_busy    = 1'b1;
        manual_en    = 1'b0;
        mem_rdata    = '0;

        // Test 1: reset values, then no issue while initial_busy/busy are held
        repeat (3) @(negedge clk);
        check("rst_ready_low", req_ready, 1'b0);
        check_reset_outputs("rst");
        n_reset = 1'b1;
        @(negedge clk);
        check("rst_ready_high", req_ready, 1'b1);
        push(1'b1, 22'h000123, 8'h5A);
        repeat (10) @(negedge clk);
        check("t1_no_issue", n_issued, 0);
        initial_busy = 1'b0;
        hold_busy    = 1'b0;
        wait_issued(1, "t1_issue_wait");
        check("t1_addr", last_addr, 22'h000123);
        check("t1_wdata", last_wdata, 8'h5A);
        @(negedge clk);
        check("t1_pulse_cleared", mem_wr, 1'b0);
        drain("t1_drain");

        // Test 2: writes spaced by a 14-cycle busy window
        wr_busy_len = 14;
        base = issue_cyc.size();
        push(1'b1, 22'h000200, 8'h11);
        push(1'b1, 22'h000201, 8'h22);
        wait_issued(base + 2, "t2_issue_wait");
        if (issue_cyc.size() >= base + 2)
            check("t2_gap", (issue_cyc[base + 1] - issue_cyc[base] >= 15), 1'b1);
        drain("t2_drain");
        wr_busy_len = 3;

        // Test 3: read back with a 5-cycle data latency
        rd_lat = 5;
        rsp_base = n_rsp;
        push(1'b0, 22'h000123, 8'h00);
        drain("t3_drain");
        check("t3_rsp_count", n_rsp, rsp_base + 1);
        check("t3_rdata", last_rsp_data, 8'h5A);
        check("t3_timeout", last_rsp_to, 1'b0);

        // Test 4: fill the queue while the port is busy
        hold_busy = 1'b1;
        base = n_issued;
        for (int i = 0; i < 4; i++)
            push(1'($urandom_range(0, 1)), 22'($urandom_range(0, 7)), 8'($urandom));
        @(negedge clk);
        check("t4_full", req_ready, 1'b0);
        fork
            push(1'b1, 22'h000005, 8'hC3);
            begin
                repeat (6) @(negedge clk);
                hold_busy = 1'b0;
            end
        join
        check("t4_fifth_after_pop", (n_issued > base), 1'b1);
        drain("t4_drain");
        check("t4_all_issued", n_issued, base + 5);

        // Random traffic with varying port timing and calibration stalls
        for (int i = 0; i < 40; i++) begin
            wr_busy_len = $urandom_range(1, 6);
            rd_lat      = $urandom_range(1, 6);
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                initial_busy = 1'b1;
                repeat ($urandom_range(1, 4)) @(negedge clk);
                initial_busy = 1'b0;
            end
            push(1'($urandom_range(0, 1)), 22'($urandom_range(0, 7)), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain("rand_drain");

        // Test 5: read that never returns data
        rd_respond = 1'b0;
        rsp_base = n_rsp;
`ifdef PSRAM_TIMEOUT_EN
        push(1'b0, 22'h3FFFFF, 8'h00, 1'b1);
        drain("t5_drain");
        check("t5_rsp_count", n_rsp, rsp_base + 1);
        check("t5_timeout_flag", last_rsp_to, 1'b1);
        check("t5_timeout_data", last_rsp_data, 8'hFF);
        // pulse cycle, then 64 watchdog cycles in ST_RWAIT, then the response cycle
        check("t5_timeout_latency", last_rsp_cyc - last_rd_cyc, 65);
        push(1'b0, 22'h000010, 8'h00);
        repeat (10) @(negedge clk);
`else
        push(1'b0, 22'h3FFFFF, 8'h00);
        repeat (100) @(negedge clk);
        check("t5_stuck_not_idle", idle, 1'b0);
        check("t5_no_rsp", n_rsp, rsp_base);
`endif

        // Test 6: reset while waiting for read data, then a late data strobe
        check("t6_in_rwait", idle, 1'b0);
        rsp_base = n_rsp;
        @(negedge clk);
        n_reset = 1'b0;
        exp_issue.delete();
        exp_rsp.delete();
        @(negedge clk);
        check("t6_ready_low", req_ready, 1'b0);
        check_reset_outputs("t6_rst");
        n_reset   = 1'b1;
        mem_rdata = 8'h77;
        manual_en = 1'b1;
        @(negedge clk);
        manual_en = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("t6_after");
        check("t6_no_rsp", n_rsp, rsp_base);
        check("t6_ready_high", req_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
